// File: rtl/acc_cpu_pkg.sv
// Shared types and default geometry for the handshaked accumulator CPU.
// Optional multiplier is controlled by the MUL_EN macro (see acc_cpu_alu).
package acc_cpu_pkg;

  localparam int DATA_W_DEF       = 16;
  localparam int ADDR_W_DEF       = 13;
  localparam int INDIRECT_PTR_DEF = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_NAND = 3'b001,
    OP_SRL  = 3'b010,
    OP_LT   = 3'b011,
    OP_BZ   = 3'b100,
    OP_CP2W = 3'b101,
    OP_CPFW = 3'b110,
    OP_MUL  = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_PTR,
    S_OPND,
    S_EXEC,
    S_WRITE
  } state_e;

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational W-update datapath of the accumulator CPU.
// Define MUL_EN to build the half-width multiplier; otherwise opcode 111 leaves W unchanged.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  opcode_e           opc_i,
  input  logic [DATA_W-1:0] w_i,
  input  logic [DATA_W-1:0] op_i,
  output logic [DATA_W-1:0] newW_o
);

  localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);
  localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);

`ifdef MUL_EN
  localparam int HALF = DATA_W / 2;
  logic [DATA_W-1:0] mulA;
  logic [DATA_W-1:0] mulB;
  assign mulA = {{(DATA_W-HALF){1'b0}}, w_i[HALF-1:0]};
  assign mulB = {{(DATA_W-HALF){1'b0}}, op_i[HALF-1:0]};
`endif

  always_comb begin
    newW_o = w_i;
    case (opc_i)
      OP_ADD:  newW_o = w_i + op_i;
      OP_NAND: newW_o = ~(w_i & op_i);
      // Operands above the word width turn SRL into a left shift by the excess.
      OP_SRL: begin
        if (op_i <= SHIFT_LIM) newW_o = w_i >> op_i;
        else                   newW_o = w_i << (op_i - SHIFT_LIM);
      end
      OP_LT:   newW_o = (w_i < op_i) ? ONE : '0;
      OP_CP2W: newW_o = op_i;
`ifdef MUL_EN
      OP_MUL:  newW_o = mulA * mulB;
`else
      OP_MUL:  newW_o = w_i;
`endif
      default: newW_o = w_i;
    endcase
  end

endmodule

// File: rtl/acc_cpu_hs.sv
// Accumulator CPU whose every memory access uses a req/ack handshake.
// Opcode 111 behaviour depends on the MUL_EN macro (multiply when defined, NOP otherwise).
module acc_cpu_hs
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int INDIRECT_PTR = INDIRECT_PTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_fromRAM,
  input  logic              memAck,
  output logic              memReq,
  output logic              wrEn,
  output logic [ADDR_W-1:0] addr_toRAM,
  output logic [DATA_W-1:0] data_toRAM,
  output logic [ADDR_W-1:0] pCounter,
  output logic [DATA_W-1:0] wOut
);

  localparam logic [ADDR_W-1:0] PTR_ADDR = ADDR_W'(INDIRECT_PTR);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

  state_e            state_q;
  opcode_e           opc_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] op_q;
  logic [DATA_W-1:0] w_q;
  logic [DATA_W-1:0] wData_q;
  logic              memReq_q;
  logic              wrEn_q;

  opcode_e           fetchOpc_d;
  logic [ADDR_W-1:0] fetchA_d;
  logic [ADDR_W-1:0] pc_d;
  logic [DATA_W-1:0] w_d;
  logic              ack;

  assign ack = memReq_q & memAck;

  always_comb begin
    fetchOpc_d = opcode_e'(data_fromRAM[DATA_W-1:ADDR_W]);
    fetchA_d   = data_fromRAM[ADDR_W-1:0];
    pc_d       = pc_q + PC_ONE;
    if (opc_q == OP_BZ && w_q == '0) pc_d = op_q[ADDR_W-1:0];
  end

  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .opc_i  (opc_q),
    .w_i    (w_q),
    .op_i   (op_q),
    .newW_o (w_d)
  );

  // addr_q doubles as the latched field A once the instruction has been fetched.
  // memReq_q resets to 1 so the fetch of address 0 is up as soon as rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      opc_q    <= OP_ADD;
      pc_q     <= '0;
      addr_q   <= '0;
      op_q     <= '0;
      w_q      <= '0;
      wData_q  <= '0;
      memReq_q <= 1'b1;
      wrEn_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (ack) begin
            opc_q <= fetchOpc_d;
            if (fetchA_d == '0) begin
              state_q <= S_PTR;
              addr_q  <= PTR_ADDR;
            end else if (fetchOpc_d == OP_CPFW) begin
              state_q <= S_WRITE;
              addr_q  <= fetchA_d;
              wrEn_q  <= 1'b1;
              wData_q <= w_q;
            end else begin
              state_q <= S_OPND;
              addr_q  <= fetchA_d;
            end
          end
        end
        S_PTR: begin
          if (ack) begin
            addr_q <= fetchA_d;
            if (opc_q == OP_CPFW) begin
              state_q <= S_WRITE;
              wrEn_q  <= 1'b1;
              wData_q <= w_q;
            end else begin
              state_q <= S_OPND;
            end
          end
        end
        S_OPND: begin
          if (ack) begin
            op_q     <= data_fromRAM;
            state_q  <= S_EXEC;
            memReq_q <= 1'b0;
          end
        end
        S_EXEC: begin
          w_q      <= w_d;
          pc_q     <= pc_d;
          state_q  <= S_FETCH;
          memReq_q <= 1'b1;
          addr_q   <= pc_d;
        end
        S_WRITE: begin
          if (ack) begin
            pc_q    <= pc_d;
            state_q <= S_FETCH;
            wrEn_q  <= 1'b0;
            wData_q <= '0;
            addr_q  <= pc_d;
          end
        end
        default: begin
          state_q  <= S_FETCH;
          memReq_q <= 1'b1;
          wrEn_q   <= 1'b0;
          addr_q   <= pc_q;
        end
      endcase
    end
  end

  assign memReq     = memReq_q & ~rst;
  assign wrEn       = wrEn_q;
  assign addr_toRAM = addr_q;
  assign data_toRAM = wData_q;
  assign pCounter   = pc_q;
  assign wOut       = w_q;

endmodule

// File: tb/tb_acc_cpu_hs.sv
// Directed self-checking bench for acc_cpu_hs against a wait-state-capable memory model.
// Expected W after opcode 111 follows the MUL_EN macro.
module tb_acc_cpu_hs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_fromRAM;
  logic        memAck;
  logic        memReq;
  logic        wrEn;
  logic [12:0] addr_toRAM;
  logic [15:0] data_toRAM;
  logic [12:0] pCounter;
  logic [15:0] wOut;

  logic [15:0] mem [0:8191];
  logic [12:0] logAddr [$];
  int          waitCycles = 0;
  int          waitCnt = 0;
  bit          holdWrites = 1'b0;
  int          checks = 0;
  int          failures = 0;

`ifdef MUL_EN
  localparam logic [15:0] EXP_MUL  = 16'h0120;
  localparam logic [15:0] EXP_NAND = 16'hFFDF;
  localparam logic [15:0] EXP_LT   = 16'h0001;
  localparam logic [15:0] EXP_ADD  = 16'h0000;
`else
  localparam logic [15:0] EXP_MUL  = 16'h0312;
  localparam logic [15:0] EXP_NAND = 16'hFFED;
  localparam logic [15:0] EXP_LT   = 16'h0000;
  localparam logic [15:0] EXP_ADD  = 16'hFFFF;
`endif

  acc_cpu_hs dut (
    .clk          (clk),
    .rst          (rst),
    .data_fromRAM (data_fromRAM),
    .memAck       (memAck),
    .memReq       (memReq),
    .wrEn         (wrEn),
    .addr_toRAM   (addr_toRAM),
    .data_toRAM   (data_toRAM),
    .pCounter     (pCounter),
    .wOut         (wOut)
  );

  always #5 clk = ~clk;

  // Memory responder: answers on the falling edge so the DUT samples a stable ack.
  initial begin
    memAck = 1'b0;
    data_fromRAM = 16'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        memAck = 1'b0;
        waitCnt = 0;
      end else begin
        if (memAck) waitCnt = 0;
        if (memReq && !(holdWrites && wrEn) && waitCnt >= waitCycles) begin
          memAck = 1'b1;
          data_fromRAM = wrEn ? 16'h0 : mem[addr_toRAM];
          if (wrEn) mem[addr_toRAM] = data_toRAM;
          logAddr.push_back(addr_toRAM);
        end else begin
          memAck = 1'b0;
          if (memReq) waitCnt++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    logAddr.delete();
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_memReq", {31'd0, memReq}, 32'd0);
    checkOutput("rst_pc", {19'd0, pCounter}, 32'd0);
    checkOutput("rst_w", {16'd0, wOut}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  initial begin
    // Direct ADD, zero wait states
    clearMem();
    mem[0] = 16'h0005; mem[5] = 16'h0007;
    applyReset();
    #1 checkOutput("first_fetch_req", {31'd0, memReq}, 32'd1);
    checkOutput("first_fetch_addr", {19'd0, addr_toRAM}, 32'd0);
    applyStimulus(2);
    checkOutput("add_w_before", {16'd0, wOut}, 32'd0);
    applyStimulus(1);
    checkOutput("add_w", {16'd0, wOut}, 32'd7);
    checkOutput("add_pc", {19'd0, pCounter}, 32'd1);

    // Indirect CP2W, two wait cycles per access
    clearMem();
    mem[0] = 16'hA000; mem[4] = 16'h0010; mem[16'h10] = 16'h1234;
    waitCycles = 2;
    applyReset();
    applyStimulus(9);
    checkOutput("ind_w_early", {16'd0, wOut}, 32'd0);
    applyStimulus(1);
    checkOutput("ind_w", {16'd0, wOut}, 32'h1234);
    checkOutput("ind_pc", {19'd0, pCounter}, 32'd1);
    checkOutput("ind_nacc", logAddr.size(), 32'd3);
    if (logAddr.size() == 3) begin
      checkOutput("ind_a0", {19'd0, logAddr[0]}, 32'h0);
      checkOutput("ind_a1", {19'd0, logAddr[1]}, 32'h4);
      checkOutput("ind_a2", {19'd0, logAddr[2]}, 32'h10);
    end
    waitCycles = 0;

    // SRL boundaries, CPfW stall and reset during a write
    clearMem();
    mem[0] = 16'hA030; mem[16'h30] = 16'h8001;
    mem[1] = 16'h4031; mem[16'h31] = 16'd1;
    mem[2] = 16'h4032; mem[16'h32] = 16'd17;
    mem[3] = 16'hC020;
    applyReset();
    applyStimulus(3);
    checkOutput("cp2w_w", {16'd0, wOut}, 32'h8001);
    applyStimulus(3);
    checkOutput("srl1_w", {16'd0, wOut}, 32'h4000);
    applyStimulus(3);
    checkOutput("srl17_w", {16'd0, wOut}, 32'h8000);
    checkOutput("srl17_pc", {19'd0, pCounter}, 32'd3);
    holdWrites = 1'b1;
    applyStimulus(1);
    checkOutput("wr_req", {31'd0, memReq}, 32'd1);
    checkOutput("wr_en", {31'd0, wrEn}, 32'd1);
    checkOutput("wr_addr", {19'd0, addr_toRAM}, 32'h20);
    checkOutput("wr_data", {16'd0, data_toRAM}, 32'h8000);
    checkOutput("wr_nacc", logAddr.size(), 32'd7);
    applyStimulus(3);
    checkOutput("wr_hold_addr", {19'd0, addr_toRAM}, 32'h20);
    checkOutput("wr_hold_en", {31'd0, wrEn}, 32'd1);
    checkOutput("wr_hold_nacc", logAddr.size(), 32'd7);
    rst = 1'b1;
    #1;
    checkOutput("midrst_req", {31'd0, memReq}, 32'd0);
    checkOutput("midrst_wren", {31'd0, wrEn}, 32'd0);
    checkOutput("midrst_addr", {19'd0, addr_toRAM}, 32'd0);
    checkOutput("midrst_data", {16'd0, data_toRAM}, 32'd0);
    checkOutput("midrst_pc", {19'd0, pCounter}, 32'd0);
    checkOutput("midrst_w", {16'd0, wOut}, 32'd0);
    holdWrites = 1'b0;
    logAddr.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("post_rst_req", {31'd0, memReq}, 32'd1);
    checkOutput("post_rst_addr", {19'd0, addr_toRAM}, 32'd0);
    checkOutput("post_rst_wren", {31'd0, wrEn}, 32'd0);
    applyStimulus(11);
    checkOutput("cpfw_pc", {19'd0, pCounter}, 32'd4);
    checkOutput("cpfw_mem", {16'd0, mem[16'h20]}, 32'h8000);
    checkOutput("cpfw_nacc", logAddr.size(), 32'd8);
    if (logAddr.size() == 8) begin
      checkOutput("cpfw_fetch", {19'd0, logAddr[6]}, 32'h3);
      checkOutput("cpfw_wraddr", {19'd0, logAddr[7]}, 32'h20);
    end

    // BZ taken / not taken and PC wrap
    clearMem();
    mem[0]       = 16'h8040; mem[16'h40] = 16'h0100;
    mem[16'h100] = 16'hA041; mem[16'h41] = 16'h0003;
    mem[16'h101] = 16'h8040;
    mem[16'h102] = 16'hA042; mem[16'h42] = 16'h0000;
    mem[16'h103] = 16'h8043; mem[16'h43] = 16'h1FFF;
    mem[16'h1FFF] = 16'h0044; mem[16'h44] = 16'h0002;
    applyReset();
    applyStimulus(3);
    checkOutput("bz_taken_pc", {19'd0, pCounter}, 32'h100);
    applyStimulus(3);
    checkOutput("bz_setw", {16'd0, wOut}, 32'd3);
    applyStimulus(3);
    checkOutput("bz_not_taken_pc", {19'd0, pCounter}, 32'h102);
    applyStimulus(6);
    checkOutput("bz_to_top_pc", {19'd0, pCounter}, 32'h1FFF);
    applyStimulus(3);
    checkOutput("wrap_pc", {19'd0, pCounter}, 32'h0);
    checkOutput("wrap_w", {16'd0, wOut}, 32'd2);

    // MUL (or NOP), NAND, LT, ADD overflow, SRL by exactly the width
    clearMem();
    mem[0] = 16'hA050; mem[16'h50] = 16'h0312;
    mem[1] = 16'hE051; mem[16'h51] = 16'h0410;
    mem[2] = 16'h2052; mem[16'h52] = 16'h00FF;
    mem[3] = 16'h6053; mem[16'h53] = 16'hFFE0;
    mem[4] = 16'h0054; mem[16'h54] = 16'hFFFF;
    mem[5] = 16'hA055; mem[16'h55] = 16'hBEEF;
    mem[6] = 16'h4056; mem[16'h56] = 16'd16;
    applyReset();
    applyStimulus(6);
    checkOutput("mul_w", {16'd0, wOut}, {16'd0, EXP_MUL});
    checkOutput("mul_pc", {19'd0, pCounter}, 32'd2);
    applyStimulus(3);
    checkOutput("nand_w", {16'd0, wOut}, {16'd0, EXP_NAND});
    applyStimulus(3);
    checkOutput("lt_w", {16'd0, wOut}, {16'd0, EXP_LT});
    applyStimulus(3);
    checkOutput("add_wrap_w", {16'd0, wOut}, {16'd0, EXP_ADD});
    applyStimulus(6);
    checkOutput("srl16_w", {16'd0, wOut}, 32'd0);
    checkOutput("srl16_pc", {19'd0, pCounter}, 32'd7);

    // Indirect CPfW, zero wait states
    clearMem();
    mem[4] = 16'h0060;
    mem[0] = 16'hA061; mem[16'h61] = 16'h5A5A;
    mem[1] = 16'hC000;
    applyReset();
    applyStimulus(5);
    checkOutput("icpfw_pc_early", {19'd0, pCounter}, 32'd1);
    applyStimulus(1);
    checkOutput("icpfw_pc", {19'd0, pCounter}, 32'd2);
    checkOutput("icpfw_mem", {16'd0, mem[16'h60]}, 32'h5A5A);
    checkOutput("icpfw_nacc", logAddr.size(), 32'd5);
    if (logAddr.size() == 5) begin
      checkOutput("icpfw_ptr", {19'd0, logAddr[3]}, 32'h4);
      checkOutput("icpfw_wraddr", {19'd0, logAddr[4]}, 32'h60);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_cpu_hs.md
# acc_cpu_hs

Parametrised successor to the team's 8-opcode accumulator CPU. It keeps the single-W-register ISA, with ADD, NAND, SRL, LT, BZ, CP2W, CPfW and MUL, plus indirect addressing through a pointer word. Data and address widths are generalised, and the pointer location is configurable. All memory traffic goes through a req/ack handshake, so the core runs against RAM or a bus bridge with any number of wait states.

## Interface
Parameters:
- DATA_W, 16: data word width; must equal ADDR_W+3.
- ADDR_W, 13: address width and instruction address-field width.
- INDIRECT_PTR, 4: address of the pointer word used when the instruction address field is 0.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- data_fromRAM  in  DATA_W  read data; valid in any cycle where memAck=1 for a read.
- memAck  in  1  completes the current access at the next rising edge.
- memReq  out  1  access request; held with all access fields until acknowledged.
- wrEn  out  1  1 = write access; meaningful only while memReq=1.
- addr_toRAM  out  ADDR_W  access address.
- data_toRAM  out  DATA_W  write data (equals W during writes, else 0).
- pCounter  out  ADDR_W  program counter.
- wOut  out  DATA_W  W register, for debug and verification.

## Operation
- Instruction word: opcode = [DATA_W-1:ADDR_W], field A = [ADDR_W-1:0].
- Opcodes:
  - 000 ADD: W += op (mod 2^DATA_W).
  - 001 NAND: W = ~(W & op).
  - 010 SRL: if op ≤ DATA_W then W >>= op, else W <<= (op − DATA_W); shifts ≥ DATA_W give 0.
  - 011 LT: W = (W < op) ? 1 : 0, unsigned.
  - 100 BZ: if W == 0 then PC = op[ADDR_W-1:0], else PC+1.
  - 101 CP2W: W = op.
  - 110 CPfW: mem[A] = W.
  - 111 MUL: W = W[DATA_W/2-1:0] * op[DATA_W/2-1:0].
- Effective address: if A == 0, then A = mem[INDIRECT_PTR][ADDR_W-1:0]; otherwise A is used as-is. There is only one level of indirection. op = mem[effective A].
- All opcodes except BZ advance PC by 1. PC wraps from 2^ADDR_W−1 to 0.
- FSM states:
  - S_FETCH: memReq=1, addr=PC, wrEn=0. On ack, latch opcode and A, then go to S_PTR if A==0, else S_WRITE if CPfW, else S_OPND.
  - S_PTR: memReq=1, addr=INDIRECT_PTR. On ack, A := data, then go to S_WRITE if CPfW, else S_OPND.
  - S_OPND: memReq=1, addr=A. On ack, op := data and go to S_EXEC.
  - S_EXEC: memReq=0. Update W and PC, then go to S_FETCH.
  - S_WRITE: memReq=1, wrEn=1, addr=A, data_toRAM=W. On ack, PC+1 and go to S_FETCH.
- CPfW never reads its operand.

## Timing
- Outputs decode from registered state only; there is no combinational path from memAck or data_fromRAM to any output.
- While rst=1, all outputs are 0: memReq, wrEn, addr_toRAM, data_toRAM, pCounter and wOut. The state becomes S_FETCH, and W, PC, op and A are all cleared.
- The first fetch request (addr 0) is visible in the first cycle after rst deasserts.
- Handshake rules:
  - An access completes on a rising edge where memReq=1 and memAck=1.
  - addr, wrEn and data_toRAM stay stable until then.
  - memAck while memReq=0 is ignored.
- Zero-wait-state latency (memAck tied 1):
  - direct ALU/BZ/CP2W: 3 cycles
  - indirect ALU/BZ/CP2W: 4 cycles
  - direct CPfW: 2 cycles
  - indirect CPfW: 3 cycles
- Each wait cycle adds one cycle to the current state.
- Reset mid-access abandons the access immediately, with no completion. A write is not guaranteed to have landed.
- BZ to its own address is a legal spin loop. The core keeps fetching; it does not halt.

## Configuration
- MUL_EN defined: opcode 111 performs MUL as above.
- MUL_EN undefined: opcode 111 is a NOP. The operand is still read (same cycle count), W is unchanged, PC+1, and no multiplier is synthesised.

## Structure
- Package acc_cpu_pkg holds:
  - opcode enum (OP_ADD…OP_MUL)
  - state enum (S_FETCH, S_PTR, S_OPND, S_EXEC, S_WRITE)
  - localparam defaults for DATA_W, ADDR_W, INDIRECT_PTR
- Sub-module acc_cpu_alu: purely combinational, taking (opcode, W, op) and producing newW, in which the MUL branch is guarded by MUL_EN. BZ and PC logic stay in the top level.

## Test plan
- Reset mid-stream: assert rst during S_WRITE with memAck=0 → all outputs 0 the same cycle; after release, memReq=1 with addr 0.
- Direct ADD with zero wait states: mem[0]=0x0005 (ADD 5), mem[5]=7, W=0 → after 3 cycles W=7 and PC=1.
- Indirect CP2W with two wait cycles on every access: mem[0]=0xA000 (CP2W, A=0), mem[4]=0x0010, mem[0x10]=0x1234 → W=0x1234 after 4+6 cycles; address sequence 0, 4, 0x10.
- CPfW plus SRL boundary:
  - W=0x8001, SRL with op=1 → W=0x4000.
  - SRL with op=17 → W <<= 1.
  - CPfW to A=0x20 → memReq=1, wrEn=1, addr=0x20, data=W; no operand read occurs.
- BZ taken and not taken: W=0 with op=0x0100 → PC=0x100; W=3 → PC+1. PC=0x1FFF with a non-branch instruction → PC=0.
- MUL_EN: W=0x0312, op=0x0410 → W=0x0120 with the macro defined; W unchanged with it undefined.
